// File: rtl/memory_read_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------------------------
// memory_read_streamer: streams i_words 64-bit reads from a byte address as valid/ready beats.
// Optional MEMORY_READ_STREAMER_STATS_EN enables the saturating handshake counter. Rev 1.0
// ---------------------------------------------------------------------------------------------
module memory_read_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH+2:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_words,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_mem_read_64,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_hi,
  output logic [2:0]            o_mem_addr_lo,
  input  logic                  i_mem_busy,
  input  logic                  i_mem_error,
  input  logic [63:0]           i_mem_data,
  output logic [63:0]           o_tdata,
  output logic                  o_tvalid,
  output logic                  o_tlast,
  input  logic                  i_tready,
  output logic [31:0]           o_read_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam logic [CRD_W-1:0] c_LIMIT = CRD_W'(FIFO_DEPTH);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;
  localparam logic [1:0] c_ST_ERROR = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] hi_q, hi_d;
  logic [2:0]            lo_q, lo_d;
  logic [LEN_WIDTH-1:0]  left_q, left_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [63:0]           fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];

  logic                  w_tvalid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_head_last;
  logic                  w_issue;
  logic                  w_last_read;
  logic [CRD_W-1:0]      w_credit;

  assign w_tvalid    = (count_q != '0);
  assign w_pop       = w_tvalid & i_tready;
  assign w_flush     = i_abort | i_mem_error;
  assign w_push      = inflight_q & ~w_flush;
  assign w_head_last = fifo_last_q[rd_ptr_q];
  assign w_last_read = (left_q == LEN_WIDTH'(1));

  // Slots already owed to the FIFO; a same-cycle pop frees one before the new read is counted.
  assign w_credit = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, w_pop};
  assign w_issue  = (state_q == c_ST_RUN) & ~i_mem_busy & (left_q != '0) & (w_credit < c_LIMIT);

  always_comb begin
    state_d         = state_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    left_d          = left_q;
    inflight_d      = w_issue;
    inflight_last_d = w_issue & w_last_read;
    done_d          = 1'b0;

    if (w_issue) begin
      hi_d   = hi_q + ADDR_WIDTH'(1);
      left_d = left_q - LEN_WIDTH'(1);
    end

    case (state_q)
      c_ST_IDLE: begin
        if (i_start) begin
          if (i_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = c_ST_RUN;
            hi_d    = i_addr[ADDR_WIDTH+2:3];
            lo_d    = i_addr[2:0];
            left_d  = i_words;
          end
        end
      end
      c_ST_RUN: begin
        if (w_issue && w_last_read) begin
          state_d = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (w_pop && w_head_last) begin
          state_d = c_ST_IDLE;
          done_d  = 1'b1;
        end
      end
      c_ST_ERROR: begin
        if (i_start) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase

    if (i_mem_error) begin
      state_d         = c_ST_ERROR;
      left_d          = '0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;
    end

    if (i_abort) begin
      state_d         = c_ST_IDLE;
      left_d          = '0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q         <= c_ST_IDLE;
      hi_q            <= '0;
      lo_q            <= '0;
      left_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      hi_q            <= hi_d;
      lo_q            <= lo_d;
      left_q          <= left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (w_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      fifo_data_q[wr_ptr_q] <= i_mem_data;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign o_busy        = (state_q != c_ST_IDLE);
  assign o_done        = done_q;
  assign o_error       = (state_q == c_ST_ERROR);
  assign o_mem_read_64 = w_issue;
  assign o_mem_addr_hi = hi_q;
  assign o_mem_addr_lo = lo_q;
  assign o_tvalid      = w_tvalid;
  assign o_tdata       = w_tvalid ? fifo_data_q[rd_ptr_q] : 64'd0;
  assign o_tlast       = w_tvalid & w_head_last;

`ifdef MEMORY_READ_STREAMER_STATS_EN
  logic [31:0] read_count_q;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      read_count_q <= '0;
    end else if (w_pop && (read_count_q != 32'hFFFF_FFFF)) begin
      read_count_q <= read_count_q + 32'd1;
    end
  end

  assign o_read_count = read_count_q;
`else
  assign o_read_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_read_streamer.sv
`default_nettype none
// Directed bench for memory_read_streamer with a 1-cycle-latency unaligned memory model.
module tb_memory_read_streamer;

  logic        clk = 1'b0;
  logic        i_areset;
  logic        i_start, i_abort;
  logic [10:0] i_addr;
  logic [7:0]  i_words;
  logic        o_busy, o_done, o_error, o_mem_read_64;
  logic [7:0]  o_mem_addr_hi;
  logic [2:0]  o_mem_addr_lo;
  logic        i_mem_busy, i_mem_error;
  logic [63:0] i_mem_data = 64'd0;
  logic [63:0] o_tdata;
  logic        o_tvalid, o_tlast, i_tready;
  logic [31:0] o_read_count;

  memory_read_streamer #(.ADDR_WIDTH(8), .LEN_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_areset(i_areset), .i_start(i_start), .i_abort(i_abort),
    .i_addr(i_addr), .i_words(i_words), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_mem_read_64(o_mem_read_64), .o_mem_addr_hi(o_mem_addr_hi),
    .o_mem_addr_lo(o_mem_addr_lo), .i_mem_busy(i_mem_busy), .i_mem_error(i_mem_error),
    .i_mem_data(i_mem_data), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .i_tready(i_tready), .o_read_count(o_read_count)
  );

  always #5 clk = ~clk;

  logic [63:0] ram [256];

  function automatic logic [63:0] mem_model(input logic [7:0] hi, input logic [2:0] lo);
    logic [127:0] w;
    logic [7:0]   nx;
    nx = hi + 8'd1;
    w  = {ram[hi], ram[nx]};
    w  = w << {lo, 3'b000};
    return w[127:64];
  endfunction

  always @(posedge clk) begin
    if (o_mem_read_64) i_mem_data <= mem_model(o_mem_addr_hi, o_mem_addr_lo);
  end

  // Observation of the DUT boundary; this block is the only writer of these.
  logic [7:0]  strobe_hi [$];
  logic [63:0] beat_data [$];
  logic        beat_last [$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, busy_viol = 0;
  logic done_busy = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_mem_read_64) begin
      strobe_hi.push_back(o_mem_addr_hi);
      if (i_mem_busy) busy_viol <= busy_viol + 1;
    end
    if (o_tvalid && i_tready) begin
      beat_data.push_back(o_tdata);
      beat_last.push_back(o_tlast);
      last_hs_cyc <= cyc;
    end
    if (o_done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_busy <= o_busy;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int n);
`ifdef MEMORY_READ_STREAMER_STATS_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  words;
    int          stall;
    int          exp_stall_reads;
    int          busy_at;
    int          busy_len;
    bit          unal;
    logic [63:0] unal_data;
    int          exp_count;
  } vec_t;

  task automatic run_xfer(input vec_t v, input int idx);
    int s0, b0, d0, k, nb, sa;
    logic [7:0] hi0, hx;
    logic [63:0] ed;
    s0 = strobe_hi.size();
    b0 = beat_data.size();
    d0 = done_cnt;
    hi0 = v.addr[10:3];
    i_addr = v.addr;
    i_words = v.words;
    i_tready = (v.stall == 0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (v.busy_at != 0) begin
      repeat (v.busy_at - 1) @(negedge clk);
      i_mem_busy = 1'b1;
      sa = strobe_hi.size();
      repeat (v.busy_len) @(negedge clk);
      chk($sformatf("v%0d strobes_while_busy", idx), 64'(strobe_hi.size() - sa), 64'd0);
      chk($sformatf("v%0d busy_violations", idx), 64'(busy_viol), 64'd0);
      i_mem_busy = 1'b0;
    end
    if (v.stall != 0) begin
      repeat (v.stall) @(negedge clk);
      chk($sformatf("v%0d reads_under_stall", idx), 64'(strobe_hi.size() - s0), 64'(v.exp_stall_reads));
      i_tready = 1'b1;
    end
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d done_pulses", idx), 64'(done_cnt - d0), 64'd1);
    chk($sformatf("v%0d busy_at_done", idx), 64'(done_busy), 64'd0);
    chk($sformatf("v%0d strobe_count", idx), 64'(strobe_hi.size() - s0), 64'(v.words));
    for (int i = 0; i < int'(v.words) && (s0 + i) < strobe_hi.size(); i++) begin
      hx = hi0 + 8'(i);
      chk($sformatf("v%0d strobe_hi[%0d]", idx, i), 64'(strobe_hi[s0 + i]), 64'(hx));
    end
    nb = beat_data.size() - b0;
    chk($sformatf("v%0d beat_count", idx), 64'(nb), 64'(v.words));
    for (int i = 0; i < int'(v.words) && i < nb; i++) begin
      hx = hi0 + 8'(i);
      ed = v.unal ? v.unal_data : ram[hx];
      chk($sformatf("v%0d tdata[%0d]", idx, i), beat_data[b0 + i], ed);
      chk($sformatf("v%0d tlast[%0d]", idx, i), 64'(beat_last[b0 + i]), 64'(i == int'(v.words) - 1));
    end
    if (v.words != 0)
      chk($sformatf("v%0d done_latency", idx), 64'(done_cyc - last_hs_cyc), 64'd1);
    chk($sformatf("v%0d read_count", idx), 64'(o_read_count), 64'(exp_stat(v.exp_count)));
  endtask

  vec_t vecs [6];

  initial begin
    vec_t tail;
    int s0, b0, d0;

    vecs[0] = '{addr:11'h010, words:8'd3, stall:0,  exp_stall_reads:0, busy_at:0, busy_len:0, unal:1'b0, unal_data:64'h0, exp_count:3};
    vecs[1] = '{addr:11'h02B, words:8'd1, stall:0,  exp_stall_reads:0, busy_at:0, busy_len:0, unal:1'b1, unal_data:64'h3344_5566_7788_99AA, exp_count:4};
    vecs[2] = '{addr:11'h080, words:8'd8, stall:10, exp_stall_reads:4, busy_at:0, busy_len:0, unal:1'b0, unal_data:64'h0, exp_count:12};
    vecs[3] = '{addr:11'h7F0, words:8'd4, stall:0,  exp_stall_reads:0, busy_at:0, busy_len:0, unal:1'b0, unal_data:64'h0, exp_count:16};
    vecs[4] = '{addr:11'h018, words:8'd0, stall:0,  exp_stall_reads:0, busy_at:0, busy_len:0, unal:1'b0, unal_data:64'h0, exp_count:16};
    vecs[5] = '{addr:11'h040, words:8'd6, stall:0,  exp_stall_reads:0, busy_at:2, busy_len:3, unal:1'b0, unal_data:64'h0, exp_count:22};

    for (int i = 0; i < 256; i++) ram[i] = {32'hCAFE_0000 + 32'(i), 32'(i) * 32'h0101_0103};
    ram[5] = 64'h0011_2233_4455_6677;
    ram[6] = 64'h8899_AABB_CCDD_EEFF;

    i_areset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_addr = '0; i_words = '0;
    i_mem_busy = 1'b0; i_mem_error = 1'b0; i_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(o_busy), 64'd0);
    chk("rst done", 64'(o_done), 64'd0);
    chk("rst error", 64'(o_error), 64'd0);
    chk("rst read", 64'(o_mem_read_64), 64'd0);
    chk("rst addr_hi", 64'(o_mem_addr_hi), 64'd0);
    chk("rst tvalid", 64'(o_tvalid), 64'd0);
    chk("rst tlast", 64'(o_tlast), 64'd0);
    chk("rst tdata", o_tdata, 64'd0);
    chk("rst read_count", 64'(o_read_count), 64'd0);
    i_areset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], i);

    // Memory error mid-run, then i_start leaves ERROR without starting a transfer.
    s0 = strobe_hi.size();
    d0 = done_cnt;
    i_addr = 11'h100; i_words = 8'd8; i_tready = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("err pre tvalid", 64'(o_tvalid), 64'd1);
    i_mem_error = 1'b1;
    @(negedge clk);
    i_mem_error = 1'b0;
    chk("err error", 64'(o_error), 64'd1);
    chk("err tvalid", 64'(o_tvalid), 64'd0);
    chk("err busy", 64'(o_busy), 64'd1);
    @(negedge clk);
    chk("err held", 64'(o_error), 64'd1);
    s0 = strobe_hi.size();
    i_words = 8'd5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("err clr error", 64'(o_error), 64'd0);
    chk("err clr busy", 64'(o_busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("err clr strobes", 64'(strobe_hi.size() - s0), 64'd0);
    chk("err no done", 64'(done_cnt - d0), 64'd0);

    // Abort with a full FIFO and a read possibly in flight.
    b0 = beat_data.size();
    i_addr = 11'h200; i_words = 8'd8; i_tready = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abt pre tvalid", 64'(o_tvalid), 64'd1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abt busy", 64'(o_busy), 64'd0);
    chk("abt tvalid", 64'(o_tvalid), 64'd0);
    chk("abt tlast", 64'(o_tlast), 64'd0);
    s0 = strobe_hi.size();
    i_tready = 1'b1;
    repeat (5) @(negedge clk);
    chk("abt no done", 64'(done_cnt - d0), 64'd0);
    chk("abt no beats", 64'(beat_data.size() - b0), 64'd0);
    chk("abt no strobes", 64'(strobe_hi.size() - s0), 64'd0);

    tail = '{addr:11'h008, words:8'd2, stall:0, exp_stall_reads:0, busy_at:0, busy_len:0, unal:1'b0, unal_data:64'h0, exp_count:24};
    run_xfer(tail, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
